// File: rtl/register_unloader_pkg.sv
// Shared definitions for the register unloader: FSM encoding and default word width.
package register_unloader_pkg;

    // Word width shared with the companion 16-bit load register.
    localparam int unsigned DEFAULT_WIDTH = 16;

    // 2'd3 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } unloader_state_e;

endpackage

// File: rtl/register_unloader_piso_shift_reg.sv
// Parallel-in serial-out shift register; load has priority over shift, MSB is the serial bit.
module register_unloader_piso_shift_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Shift register state: clear, capture, or shift left with a zero fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end else if (shift) begin
            q_q <= q_q << 1;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/register_unloader.sv
// Captures a parallel word on load and streams it out MSB first over a valid/ready link,
// keeping a shadow copy of the last captured word.
module register_unloader
    import register_unloader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done
);

    unloader_state_e  state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] shreg;
    logic             load_en;
    logic             shift_en;

    register_unloader_piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load_en),
        .shift (shift_en),
        .d     (d),
        .q     (shreg)
    );

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ready      = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (load) begin
                    load_en = 1'b1;
                    count_d = CW'(WIDTH - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                sout_valid = 1'b1;
                if (sout_ready) begin
                    // Last bit goes out without shifting; count never wraps below zero.
                    if (count_q != '0) begin
                        shift_en = 1'b1;
                        count_d  = count_q - 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter and shadow register; shadow only updates on an accepted capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (load_en) begin
                out_q <= d;
            end
        end
    end

    assign out  = out_q;
    assign sout = shreg[WIDTH-1];

endmodule

// File: tb/tb_register_unloader.sv
// Directed bench for register_unloader with a serial-bit scoreboard.
module tb_register_unloader;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic [WIDTH-1:0] out;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             done;

    int checks = 0;
    int passed = 0;
    logic sb[$];

    register_unloader #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .d          (d),
        .ready      (ready),
        .out        (out),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one capture and queue the expected MSB-first bit stream.
    task automatic load_word(input logic [WIDTH-1:0] w);
        check("ready_before_load", 32'(ready), 32'd1);
        d    = w;
        load = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(w[i]);
        step();
        load = 1'b0;
    endtask

    // Consume the serial stream. mode 0: sout_ready high; mode 1: toggles 1,0,1,0.
    // noise drives load=1/d=111 throughout; max_acc>0 stops after that many accepts.
    task automatic drain(input int mode, input bit noise, input int max_acc, output int done_cyc);
        bit   stalled  = 1'b0;
        bit   finished = 1'b0;
        logic held     = 1'b0;
        logic exp;
        int   acc      = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            sout_ready = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
            if (noise) begin
                load = 1'b1;
                d    = 16'd111;
            end
            if (done) begin
                check("done_after_last_bit", sb.size(), 32'd0);
                done_cyc = cyc;
                finished = 1'b1;
                break;
            end
            if (sout_valid) begin
                if (stalled) check("stall_hold", 32'(sout), 32'(held));
                if (sout_ready) begin
                    if (sb.size() == 0) begin
                        check("extra_bit", 32'd1, 32'd0);
                    end else begin
                        exp = sb.pop_front();
                        check("bit", 32'(sout), 32'(exp));
                    end
                    stalled = 1'b0;
                    acc++;
                end else begin
                    held    = sout;
                    stalled = 1'b1;
                end
            end
            step();
            if (max_acc > 0 && acc == max_acc) begin
                finished = 1'b1;
                break;
            end
        end
        load       = 1'b0;
        sout_ready = 1'b1;
        if (!finished) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int dc;
        reset      = 1'b1;
        load       = 1'b0;
        d          = '0;
        sout_ready = 1'b0;

        // Reset and idle.
        step();
        step();
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_out", 32'(out), 32'd0);
        check("rst_sout_valid", 32'(sout_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sout", 32'(sout), 32'd0);
        step();
        check("idle_ready", 32'(ready), 32'd1);

        // Capture 20 with sout_ready held high.
        load_word(16'd20);
        check("out_20", 32'(out), 32'd20);
        check("busy_ready", 32'(ready), 32'd0);
        drain(0, 1'b0, 0, dc);
        check("done_cycle_20", dc, 32'd17);
        step();
        check("ready_cycle_18", 32'(ready), 32'd1);
        check("done_single", 32'(done), 32'd0);

        // Backpressure on 1133.
        load_word(16'd1133);
        drain(1, 1'b0, 0, dc);
        check("done_cycle_bp", dc, 32'd32);
        check("out_1133", 32'(out), 32'd1133);
        step();

        // Load ignored while busy.
        load_word(16'd20);
        drain(0, 1'b1, 0, dc);
        check("done_cycle_noise", dc, 32'd17);
        check("out_held_20", 32'(out), 32'd20);
        step();

        // Back-to-back capture as soon as ready returns.
        load_word(16'd111);
        check("out_111", 32'(out), 32'd111);
        drain(0, 1'b0, 0, dc);
        check("done_cycle_111", dc, 32'd17);
        step();

        // Reset mid-transfer after five accepted bits.
        load_word(16'd1133);
        drain(0, 1'b0, 5, dc);
        check("mid_sout_valid", 32'(sout_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_valid", 32'(sout_valid), 32'd0);
        step();
        check("mid_no_done", 32'(done), 32'd0);
        load_word(16'd20);
        check("out_after_rst", 32'(out), 32'd20);
        drain(0, 1'b0, 0, dc);
        check("done_cycle_after_rst", dc, 32'd17);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
